// File: rtl/logic_seq_pkg.sv
// Shared op-code constants, mode encoding and the bitwise op helper
// for the logic op sequencer.
package logic_seq_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NOT  = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_LAST = OP_NAND;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    function automatic logic [7:0] apply_op(
        input logic [2:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] r;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] next_op(input logic [2:0] op);
        return (op >= OP_LAST) ? OP_PASS : op + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, counting debouncer and
// rising-edge pulse generator.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            pulse <= flip && sync;
            if (sync == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/logic_op_sequencer.sv
// Steps through eight-bit bitwise ops on the switch operands, either
// on button presses or automatically after a dwell time.
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_CYCLES    = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_step,
    input  logic        btn_mode,
    output logic [15:0] led
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    logic [15:0]   sw_meta;
    logic [15:0]   sw_sync;
    logic [7:0]    result;
    logic [2:0]    op;
    logic [DW-1:0] dwell;
    mode_e         state;
    mode_e         state_next;
    logic          auto_on;
    logic          step_pulse;
    logic          mode_pulse;
    logic          step_level;
    logic          mode_level;
    logic          term;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .level (step_level),
        .pulse (step_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .level (mode_level),
        .pulse (mode_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MODE_MANUAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (mode_pulse) begin
            state_next = (state == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
        end
    end

    always_comb begin
        auto_on = (state == MODE_AUTO);
    end

    assign term = auto_on && (dwell == DWELL_LAST);

    // Step and terminal count together still advance by exactly one.
    always_ff @(posedge clk) begin
        if (rst) begin
            op    <= OP_PASS;
            dwell <= '0;
        end else begin
            if (step_pulse || term) begin
                op <= next_op(op);
            end
            if (!auto_on || step_pulse || mode_pulse || term) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
            result  <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            result  <= apply_op(op, sw_sync[7:0], sw_sync[15:8]);
        end
    end

    assign led = {4'h0, auto_on, op, result};

endmodule
